div_unit: RTL

Multi-cycle 32-bit radix-2 divider for the EX stage, alongside the ALU. It takes the same `a`/`b` operands the ALU receives, plus a start strobe from EX decode of DIV/DIVU. It holds the pipeline stalled while iterating, then presents quotient (to LO) and remainder (to HI) with a one-cycle `valid` pulse. Signed and unsigned division are supported; flush from the hazard unit annuls an in-flight operation.

---
 rtl/div_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Optional feature macro DIV_ZERO_FAST_EN: a divide by zero completes one cycle after start.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall_req,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic             dz_op;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_dvd;

  // One restoring step: the dividend register doubles as the quotient shift register.
  always_comb begin
    mag_a     = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b     = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
    shifted   = {rem, dvd[WIDTH-1]};
    diff      = shifted - {1'b0, dvs};
    qbit      = ~diff[WIDTH];
    next_rem  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    next_dvd  = {dvd[WIDTH-2:0], qbit};
    stall_req = ((state == IDLE) && start && !annul) || (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dz_op     <= 1'b0;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (annul) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
`ifdef DIV_ZERO_FAST_EN
              if (b == '0) begin
                state     <= DONE;
                valid     <= 1'b1;
                quotient  <= '1;
                remainder <= a;
                div_zero  <= 1'b1;
              end else begin
`else
              begin
`endif
                state  <= BUSY;
                dvd    <= mag_a;
                dvs    <= mag_b;
                rem    <= '0;
                cnt    <= '0;
                sign_q <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r <= signed_div && a[WIDTH-1];
                dz_op  <= (b == '0);
              end
            end
          end
          BUSY: begin
            rem <= next_rem;
            dvd <= next_dvd;
            cnt <= cnt + 1'b1;
            // Results are committed straight from the final iteration's values.
            if (cnt == LAST) begin
              state     <= DONE;
              valid     <= 1'b1;
              quotient  <= sign_q ? (~next_dvd + 1'b1) : next_dvd;
              remainder <= sign_r ? (~next_rem + 1'b1) : next_rem;
              div_zero  <= dz_op;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
